eth_encap_tx_sched: RTL and testbench
=====================================

# eth_encap_tx_sched

Transmit scheduler for the Ethernet encapsulation path. It arbitrates between three packet sources: the TLP FIFO, the NetTLP command FIFO and the PCIe-config FIFO. It issues one packet grant at a time to the encapsulation core and holds it until that packet's last beat is accepted. TLP traffic has priority, bounded by a weight so that command and config packets are never starved. Command and config sources are served round-robin between themselves, and an optional inter-packet gap can be inserted after each packet.

## Interface
- TLP_WEIGHT, 4: maximum consecutive TLP grants while a CMD/CFG request is pending; legal range 1..15.
- IFG_CYCLES, 0: idle cycles inserted after each pkt_done; legal range 0..255.
- CNT_W, 32: width of statistics counters.
- eth_clk  in  1  clock, the sole clock.
- eth_rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = new grants allowed; 0 = finish the in-flight packet, then no new grants.
- req_tlp  in  1  TLP FIFO has a valid head entry (!empty && data_valid).
- req_cmd  in  1  command FIFO has a valid head entry.
- req_cfg  in  1  PCIe-config FIFO has a valid head entry.
- grant_valid  out  1  a grant is offered.
- grant  out  3  one-hot {cfg, cmd, tlp}; all zeros when no grant is held.
- grant_ready  in  1  the core accepts the offered grant; the handshake completes on grant_valid && grant_ready.
- pkt_done  in  1  the granted packet's tlast beat was accepted (tvalid && tready && tlast).
- busy  out  1  a grant is offered or in flight.
- err_unexp_done  out  1  sticky flag: pkt_done seen outside BUSY.
- stat_tlp_pkts, stat_cmd_pkts, stat_cfg_pkts  out  CNT_W each  completed-packet counts; present only with TX_SCHED_STATS_EN.

## Operation
- States: IDLE, OFFER, BUSY, GAP.
- IDLE:
  - Stay in IDLE if enable=0 or no request is asserted.
  - Otherwise select a source, register it into grant, and go to OFFER.
- Selection rule, evaluated in IDLE:
  - If req_tlp=1 and (tlp_run < TLP_WEIGHT, or no CMD/CFG request), choose TLP.
  - Else if exactly one of req_cmd/req_cfg is set, choose it.
  - Else if both are set, choose the one that was not last served (ctl_last pointer; reset value = cfg, so cmd goes first).
- tlp_run, 4 bits:
  - Increments on each TLP grant handshake, saturating at TLP_WEIGHT.
  - Clears to 0 on any CMD or CFG handshake.
- ctl_last updates on each CMD or CFG handshake.
- OFFER:
  - grant_valid=1 and grant is held stable until grant_ready.
  - On the handshake, go to BUSY.
  - A request deasserting while in OFFER does not withdraw the grant.
- BUSY:
  - grant_valid=0 and grant is held.
  - On pkt_done: clear grant, update statistics, and go to GAP if IFG_CYCLES>0, else to IDLE.
- GAP: an 8-bit counter counts IFG_CYCLES cycles, then the block goes to IDLE.
- pkt_done in IDLE, OFFER or GAP:
  - It is ignored for sequencing and sets err_unexp_done.
  - Only reset clears err_unexp_done.
- When enable falls during OFFER or BUSY, the current packet completes normally and the block then stays in IDLE.
- Reset values:
  - State IDLE.
  - grant_valid=0, grant=3'b000, busy=0, err_unexp_done=0.
  - tlp_run=0, ctl_last=cfg, gap counter=0, all statistics counters 0.
- Asserting reset mid-operation returns everything to the reset values immediately, asynchronously. Any in-flight packet is abandoned; the core must also be reset.

## Timing
- Request sampled in IDLE at cycle n -> grant_valid=1 at cycle n+1.
- Handshake at cycle m -> BUSY from cycle m+1.
- pkt_done at cycle k:
  - With IFG_CYCLES=0: IDLE at k+1; the earliest next grant_valid is at k+2.
  - With IFG_CYCLES=G: GAP for cycles k+1..k+G, IDLE at k+G+1, next grant_valid at k+G+2.
- busy is registered: it is 1 in OFFER, BUSY and GAP.
- grant and grant_valid are registered outputs with no combinational path from the req_* inputs.
- Statistics counters update at k+1 and wrap modulo 2^CNT_W.

## Configuration
- TX_SCHED_STATS_EN defined:
  - The three stat_* counters are implemented.
  - Each increments by 1 on pkt_done in BUSY for the granted source.
- TX_SCHED_STATS_EN undefined:
  - The stat_* ports are absent from the port list.
  - No counter logic is generated.
  - Scheduling behaviour is identical in both builds.

## Test plan
- Single CMD: req_cmd=1 at cycle 0 with grant_ready tied to 1 -> grant_valid at cycle 1 with grant=3'b010; pkt_done at cycle 4 -> grant=0 at cycle 5, stat_cmd_pkts=1.
- TLP weight: TLP_WEIGHT=4, req_tlp and req_cmd held at 1, each packet done 3 cycles after its handshake -> grant order TLP,TLP,TLP,TLP,CMD,TLP,TLP,TLP,TLP,CMD.
- CMD/CFG round-robin: req_cmd=req_cfg=1 held, req_tlp=0 -> grant order CMD,CFG,CMD,CFG.
- Gap and enable:
  - IFG_CYCLES=3 with pkt_done at cycle 10 -> next grant_valid at cycle 15.
  - enable=0 during BUSY -> after pkt_done, no grant is issued while requests remain high.
- Protocol error: pkt_done pulsed in IDLE -> err_unexp_done=1 with state unchanged. Async reset asserted in BUSY -> grant=0, busy=0 and err_unexp_done=0 before the next clock edge.
- Counter wrap: CNT_W=4 with 16 TLP packets -> stat_tlp_pkts returns to 0. A build without TX_SCHED_STATS_EN produces the same grant sequence.

Source files
------------

// File: rtl/eth_encap_tx_sched.sv
// eth_encap_tx_sched: weighted-priority TX scheduler for TLP/CMD/CFG
// sources, with one grant in flight and an optional inter-packet gap.
// Ports: eth_clk, eth_rst_n (async, active-low), enable,
//   req_tlp/req_cmd/req_cfg, grant_valid, grant {cfg,cmd,tlp},
//   grant_ready, pkt_done, busy, err_unexp_done,
//   stat_tlp_pkts/stat_cmd_pkts/stat_cfg_pkts (TX_SCHED_STATS_EN only).
// Params: TLP_WEIGHT (1..15), IFG_CYCLES (0..255), CNT_W.
module eth_encap_tx_sched #(
  parameter int TLP_WEIGHT = 4,
  parameter int IFG_CYCLES = 0,
  parameter int CNT_W      = 32
) (
  input  logic             eth_clk,
  input  logic             eth_rst_n,
  input  logic             enable,
  input  logic             req_tlp,
  input  logic             req_cmd,
  input  logic             req_cfg,
  output logic             grant_valid,
  output logic [2:0]       grant,
  input  logic             grant_ready,
  input  logic             pkt_done,
  output logic             busy,
  output logic             err_unexp_done
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_tlp_pkts,
  output logic [CNT_W-1:0] stat_cmd_pkts,
  output logic [CNT_W-1:0] stat_cfg_pkts
`endif
);

  localparam logic [3:0] WGT = 4'(TLP_WEIGHT);
  localparam logic [7:0] IFG = 8'(IFG_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFER,
    S_BUSY,
    S_GAP
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [3:0] tlp_run_q, tlp_run_d;
  logic       ctl_last_q, ctl_last_d;
  logic [7:0] gap_q, gap_d;
  logic       err_q, err_d;

  logic       any_req;
  logic       ctl_req;
  logic       start;
  logic       hs;
  logic       done_ok;
  logic [2:0] sel;

  assign ctl_req = req_cmd | req_cfg;
  assign any_req = req_tlp | ctl_req;
  assign start   = (state_q == S_IDLE) & enable & any_req;
  assign hs      = (state_q == S_OFFER) & grant_ready;
  assign done_ok = (state_q == S_BUSY) & pkt_done;

  // ctl_last_q: 1 = cfg served last, 0 = cmd served last
  always_comb begin
    sel = 3'b000;
    if (req_tlp && ((tlp_run_q < WGT) || !ctl_req)) begin
      sel = 3'b001;
    end else if (req_cmd && req_cfg) begin
      sel = ctl_last_q ? 3'b010 : 3'b100;
    end else if (req_cmd) begin
      sel = 3'b010;
    end else if (req_cfg) begin
      sel = 3'b100;
    end
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_OFFER;
      end
      S_OFFER: begin
        if (grant_ready) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (pkt_done) begin
          state_d = (IFG != 8'd0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == IFG - 8'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_valid    = (state_q == S_OFFER);
    busy           = (state_q != S_IDLE);
    grant          = grant_q;
    err_unexp_done = err_q;
  end

  always_comb begin
    grant_d = grant_q;
    if (start) begin
      grant_d = sel;
    end else if (done_ok) begin
      grant_d = 3'b000;
    end
  end

  always_comb begin
    tlp_run_d  = tlp_run_q;
    ctl_last_d = ctl_last_q;
    if (hs) begin
      if (grant_q[0]) begin
        if (tlp_run_q < WGT) tlp_run_d = tlp_run_q + 4'd1;
      end else begin
        tlp_run_d  = 4'd0;
        ctl_last_d = grant_q[2];
      end
    end
  end

  always_comb begin
    gap_d = gap_q;
    if (done_ok) begin
      gap_d = 8'd0;
    end else if (state_q == S_GAP) begin
      gap_d = gap_q + 8'd1;
    end
  end

  assign err_d = err_q | (pkt_done & (state_q != S_BUSY));

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      grant_q    <= 3'b000;
      tlp_run_q  <= 4'd0;
      ctl_last_q <= 1'b1;
      gap_q      <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      tlp_run_q  <= tlp_run_d;
      ctl_last_q <= ctl_last_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
    end
  end

`ifdef TX_SCHED_STATS_EN
  logic [CNT_W-1:0] st_tlp_q, st_tlp_d;
  logic [CNT_W-1:0] st_cmd_q, st_cmd_d;
  logic [CNT_W-1:0] st_cfg_q, st_cfg_d;

  always_comb begin
    st_tlp_d = st_tlp_q;
    st_cmd_d = st_cmd_q;
    st_cfg_d = st_cfg_q;
    if (done_ok) begin
      if (grant_q[0]) st_tlp_d = st_tlp_q + 1'b1;
      if (grant_q[1]) st_cmd_d = st_cmd_q + 1'b1;
      if (grant_q[2]) st_cfg_d = st_cfg_q + 1'b1;
    end
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      st_tlp_q <= '0;
      st_cmd_q <= '0;
      st_cfg_q <= '0;
    end else begin
      st_tlp_q <= st_tlp_d;
      st_cmd_q <= st_cmd_d;
      st_cfg_q <= st_cfg_d;
    end
  end

  assign stat_tlp_pkts = st_tlp_q;
  assign stat_cmd_pkts = st_cmd_q;
  assign stat_cfg_pkts = st_cfg_q;
`endif

endmodule

// File: tb/tb_eth_encap_tx_sched.sv
// tb_eth_encap_tx_sched: directed checks of grant order, timing,
// gap, enable, error flag, async reset and (optionally) stats.
`timescale 1ns/1ps
module tb_eth_encap_tx_sched;

  localparam logic [2:0] TLP = 3'b001;
  localparam logic [2:0] CMD = 3'b010;
  localparam logic [2:0] CFG = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       req_tlp, req_cmd, req_cfg;
  logic       grant_ready;
  logic       pkt_done;
  logic       gv, gv_g;
  logic [2:0] gnt, gnt_g;
  logic       busy, busy_g;
  logic       err, err_g;
`ifdef TX_SCHED_STATS_EN
  logic [3:0]  s_tlp, s_cmd, s_cfg;
  logic [31:0] s_tlp_g, s_cmd_g, s_cfg_g;
`endif

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  eth_encap_tx_sched #(
    .TLP_WEIGHT(4), .IFG_CYCLES(0), .CNT_W(4)
  ) u_dut (
    .eth_clk(clk), .eth_rst_n(rst_n), .enable(enable),
    .req_tlp(req_tlp), .req_cmd(req_cmd), .req_cfg(req_cfg),
    .grant_valid(gv), .grant(gnt), .grant_ready(grant_ready),
    .pkt_done(pkt_done), .busy(busy), .err_unexp_done(err)
`ifdef TX_SCHED_STATS_EN
    , .stat_tlp_pkts(s_tlp), .stat_cmd_pkts(s_cmd),
    .stat_cfg_pkts(s_cfg)
`endif
  );

  eth_encap_tx_sched #(
    .TLP_WEIGHT(4), .IFG_CYCLES(3), .CNT_W(32)
  ) u_gap (
    .eth_clk(clk), .eth_rst_n(rst_n), .enable(enable),
    .req_tlp(req_tlp), .req_cmd(req_cmd), .req_cfg(req_cfg),
    .grant_valid(gv_g), .grant(gnt_g), .grant_ready(grant_ready),
    .pkt_done(pkt_done), .busy(busy_g), .err_unexp_done(err_g)
`ifdef TX_SCHED_STATS_EN
    , .stat_tlp_pkts(s_tlp_g), .stat_cmd_pkts(s_cmd_g),
    .stat_cfg_pkts(s_cfg_g)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b1;
    req_tlp     = 1'b0;
    req_cmd     = 1'b0;
    req_cfg     = 1'b0;
    grant_ready = 1'b0;
    pkt_done    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cyc = 0;
  endtask

  // wait for an offer, take it, finish packet 3 cycles after handshake
  task automatic get_pkt(output logic [2:0] g);
    int n = 0;
    while (!gv && n < 20) begin
      tick();
      n++;
    end
    if (!gv) begin
      chk("grant_timeout", {31'd0, gv}, 32'd1);
      g = 3'b000;
    end else begin
      g = gnt;
      tick();
      tick();
      tick();
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] g;
    logic [2:0] wexp [10];
    logic [2:0] rexp [4];
    logic       seen;

    wexp = '{TLP, TLP, TLP, TLP, CMD, TLP, TLP, TLP, TLP, CMD};
    rexp = '{CMD, CFG, CMD, CFG};

    // reset state
    do_reset();
    chk("rst_gv", {31'd0, gv}, 32'd0);
    chk("rst_grant", {29'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // single CMD packet
    grant_ready = 1'b1;
    req_cmd     = 1'b1;
    tick();
    chk("cmd_gv", {31'd0, gv}, 32'd1);
    chk("cmd_grant", {29'd0, gnt}, {29'd0, CMD});
    chk("cmd_busy", {31'd0, busy}, 32'd1);
    req_cmd = 1'b0;
    tick();
    chk("cmd_busy_gv", {31'd0, gv}, 32'd0);
    chk("cmd_busy_grant", {29'd0, gnt}, {29'd0, CMD});
    tick();
    tick();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    chk("cmd_done_grant", {29'd0, gnt}, 32'd0);
    chk("cmd_done_busy", {31'd0, busy}, 32'd0);
    chk("cmd_gap_busy", {31'd0, busy_g}, 32'd1);
`ifdef TX_SCHED_STATS_EN
    chk("cmd_stat", {28'd0, s_cmd}, 32'd1);
    chk("cmd_stat_tlp", {28'd0, s_tlp}, 32'd0);
`endif

    // TLP weight
    do_reset();
    grant_ready = 1'b1;
    req_tlp     = 1'b1;
    req_cmd     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      get_pkt(g);
      chk($sformatf("wgt%0d", i), {29'd0, g}, {29'd0, wexp[i]});
    end

    // CMD/CFG round-robin
    do_reset();
    grant_ready = 1'b1;
    req_cmd     = 1'b1;
    req_cfg     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_pkt(g);
      chk($sformatf("rr%0d", i), {29'd0, g}, {29'd0, rexp[i]});
    end

    // offer held after request drops
    do_reset();
    req_tlp = 1'b1;
    tick();
    req_tlp = 1'b0;
    tick();
    tick();
    tick();
    chk("hold_gv", {31'd0, gv}, 32'd1);
    chk("hold_grant", {29'd0, gnt}, {29'd0, TLP});
    grant_ready = 1'b1;
    tick();
    chk("hold_hs_gv", {31'd0, gv}, 32'd0);
    chk("hold_hs_busy", {31'd0, busy}, 32'd1);

    // inter-packet gap: pkt_done at cycle 10
    do_reset();
    grant_ready = 1'b1;
    req_cmd     = 1'b1;
    while (cyc < 10) tick();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    chk("gap11_busy", {31'd0, busy_g}, 32'd1);
    chk("gap11_gv", {31'd0, gv_g}, 32'd0);
    tick();
    chk("nogap12_gv", {31'd0, gv}, 32'd1);
    tick();
    chk("gap13_busy", {31'd0, busy_g}, 32'd1);
    tick();
    chk("gap14_busy", {31'd0, busy_g}, 32'd0);
    chk("gap14_gv", {31'd0, gv_g}, 32'd0);
    tick();
    chk("gap15_gv", {31'd0, gv_g}, 32'd1);

    // enable dropped during BUSY
    do_reset();
    grant_ready = 1'b1;
    req_tlp     = 1'b1;
    req_cmd     = 1'b1;
    tick();
    chk("en_gv", {31'd0, gv}, 32'd1);
    tick();
    enable = 1'b0;
    tick();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | gv | busy;
      tick();
    end
    chk("en_off_idle", {31'd0, seen}, 32'd0);
    enable = 1'b1;
    tick();
    chk("en_resume_gv", {31'd0, gv}, 32'd1);

    // unexpected pkt_done, then async reset in BUSY
    do_reset();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_busy", {31'd0, busy}, 32'd0);
    chk("err_gv", {31'd0, gv}, 32'd0);
    tick();
    chk("err_sticky", {31'd0, err}, 32'd1);
    grant_ready = 1'b1;
    req_cfg     = 1'b1;
    tick();
    chk("cfg_grant", {29'd0, gnt}, {29'd0, CFG});
    tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", {29'd0, gnt}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);

`ifdef TX_SCHED_STATS_EN
    // 4-bit counter wrap after 16 TLP packets
    do_reset();
    grant_ready = 1'b1;
    req_tlp     = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      get_pkt(g);
      if (i == 1) chk("wrap1", {28'd0, s_tlp}, 32'd1);
      if (i == 15) chk("wrap15", {28'd0, s_tlp}, 32'd15);
      if (i == 16) chk("wrap16", {28'd0, s_tlp}, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
